// File: rtl/fft_spectrum_buffer_if.sv
// Bus between the FFT magnitude source/LCD painter and the spectrum ping-pong buffer.
// The master drives samples and painter requests; the slave returns bars and status.
interface fft_spectrum_buffer_if #(
    parameter int unsigned IN_W = 24
);
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] in_data;
    logic            in_last;
    logic            data_req;
    logic            fft_point_done;
    logic [6:0]      fft_point_cnt;
    logic [15:0]     fft_data;
    logic            buf_valid;
    logic            frame_swap;

    modport master (
        output in_valid, in_data, in_last, data_req, fft_point_done,
        input  in_ready, fft_point_cnt, fft_data, buf_valid, frame_swap
    );

    modport slave (
        input  in_valid, in_data, in_last, data_req, fft_point_done,
        output in_ready, fft_point_cnt, fft_data, buf_valid, frame_swap
    );
endinterface

// File: rtl/fft_spectrum_buffer.sv
// Ping-pong spectrum frame buffer: captures scaled/clipped FFT magnitudes into one bank while
// the painter reads the other; banks swap only at a display frame boundary.
module fft_spectrum_buffer #(
    parameter int unsigned POINTS  = 64,
    parameter int unsigned IN_W    = 24,
    parameter int unsigned SHIFT   = 8,
    parameter logic [15:0] BAR_MAX = 16'd479
) (
    input logic                    lcd_pclk,
    input logic                    rst,
    fft_spectrum_buffer_if.slave   bus
);
    localparam int unsigned AW      = $clog2(2 * POINTS);
    localparam logic [6:0]  LAST_PT = 7'(POINTS - 1);

    logic            r_wr_bank;
    logic            r_rd_bank;
    logic            r_wr_full;
    logic            r_buf_valid;
    logic            r_frame_swap;
    logic [6:0]      r_wr_idx;
    logic [6:0]      r_cnt;
    logic [7:0]      r_len [2];
    logic [15:0]     r_fft_data;
    logic [15:0]     r_mem [2 * POINTS];

    logic [IN_W-1:0] w_shifted;
    logic [15:0]     w_clip;
    logic            w_accept;
    logic            w_close;
    logic            w_wrap;
    logic            w_swap;
    logic            w_rd_hit;
    logic [AW-1:0]   w_wr_addr;
    logic [AW-1:0]   w_rd_addr;

    assign w_shifted = bus.in_data >> SHIFT;
    assign w_clip    = (w_shifted > IN_W'(BAR_MAX)) ? BAR_MAX : w_shifted[15:0];

    assign bus.in_ready = !r_wr_full && !rst;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_close      = w_accept && ((r_wr_idx == LAST_PT) || bus.in_last);

    // Swap immediately when nothing is shown yet, otherwise only at the end of a painted frame.
    assign w_wrap = bus.fft_point_done && (r_cnt == LAST_PT);
    assign w_swap = r_wr_full && (!r_buf_valid || w_wrap);

    assign w_wr_addr = AW'(r_wr_bank ? POINTS : 0) + AW'(r_wr_idx);
    assign w_rd_addr = AW'(r_rd_bank ? POINTS : 0) + AW'(r_cnt);
    assign w_rd_hit  = r_buf_valid && ({1'b0, r_cnt} < r_len[r_rd_bank]);

    always_ff @(posedge lcd_pclk) begin
        if (w_accept) begin
            r_mem[w_wr_addr] <= w_clip;
        end
    end

    always_ff @(posedge lcd_pclk) begin
        if (rst) begin
            r_wr_bank    <= 1'b0;
            r_rd_bank    <= 1'b1;
            r_wr_full    <= 1'b0;
            r_buf_valid  <= 1'b0;
            r_frame_swap <= 1'b0;
            r_wr_idx     <= 7'd0;
            r_cnt        <= 7'd0;
            r_len[0]     <= 8'd0;
            r_len[1]     <= 8'd0;
            r_fft_data   <= 16'd0;
        end else begin
            r_frame_swap <= w_swap;
            if (w_swap) begin
                r_rd_bank   <= r_wr_bank;
                r_wr_bank   <= ~r_wr_bank;
                r_wr_full   <= 1'b0;
                r_buf_valid <= 1'b1;
            end
            // Close and swap are exclusive: a close needs wr_full=0, a swap needs wr_full=1.
            if (w_close) begin
                r_len[r_wr_bank] <= {1'b0, r_wr_idx} + 8'd1;
                r_wr_idx         <= 7'd0;
                r_wr_full        <= 1'b1;
            end else if (w_accept) begin
                r_wr_idx <= r_wr_idx + 7'd1;
            end
            if (bus.fft_point_done) begin
                r_cnt <= (r_cnt == LAST_PT) ? 7'd0 : r_cnt + 7'd1;
            end
            if (bus.data_req) begin
                r_fft_data <= w_rd_hit ? r_mem[w_rd_addr] : 16'd0;
            end
        end
    end

    assign bus.fft_point_cnt = r_cnt;
    assign bus.fft_data      = r_fft_data;
    assign bus.buf_valid     = r_buf_valid;
    assign bus.frame_swap    = r_frame_swap;
endmodule
